// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single-outstanding imem handshake, a stall buffer and redirect squashing.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] TargetD,
    input  logic [31:0] RecoverPC_E,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        branched_flag_F
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
    state_t state, next_state;
    logic [31:0] pc, pc_plus4, buffer;
    logic drop, recover, taken, redirect, rsp, load_mem, load_buf;

    assign pc_plus4 = pc + 32'd4;
    assign recover  = PCSrcE == 2'b10;
    assign taken    = PCSrcE == 2'b01 && !StallD;
    assign redirect = recover || taken;
    assign rsp      = state == WAIT && imem_rvalid;
    assign load_mem = rsp && !drop && !StallD && !redirect;
    assign load_buf = state == HOLD && !StallD && !redirect;

    always_ff @(posedge clk) begin
        if (reset)
            state <= REQ;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            REQ:     next_state = imem_gnt ? WAIT : REQ;
            WAIT:    if (imem_rvalid)
                         next_state = load_mem ? (imem_gnt ? WAIT : REQ) :
                                      (!drop && !redirect && StallD) ? HOLD : REQ;
            HOLD:    next_state = (redirect || !StallD) ? REQ : HOLD;
            default: next_state = REQ;
        endcase
    end

    // A back-to-back request to the next sequential PC goes out in the response cycle.
    always_comb begin
        imem_req  = !reset && (state == REQ || load_mem);
        imem_addr = load_mem ? pc_plus4 : pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc              <= RESET_PC;
            drop            <= 1'b0;
            buffer          <= 32'h0;
            InstrD          <= 32'h0000_0013;
            PCD             <= 32'h0;
            PCPlus4D        <= 32'h0;
            ValidD          <= 1'b0;
            branched_flag_F <= 1'b0;
        end else begin
            pc <= redirect ? (recover ? RecoverPC_E : TargetD) :
                  (load_mem || load_buf) ? pc_plus4 : pc;
            // A granted request that a redirect overtakes must have its response swallowed.
            drop <= rsp ? 1'b0 :
                    drop || (redirect && (state == REQ ? imem_gnt : state == WAIT));
            if (rsp)
                buffer <= imem_rdata;
            if (load_mem || load_buf) begin
                InstrD   <= load_mem ? imem_rdata : buffer;
                PCD      <= pc;
                PCPlus4D <= pc_plus4;
                ValidD   <= 1'b1;
            end else if (redirect || !StallD) begin
                ValidD <= 1'b0;
            end
            branched_flag_F <= taken || (branched_flag_F && !recover && !load_mem && !load_buf);
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset corner sequence and randomized run against a stream-level model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  PCSrcE = 2'b00;
    logic [31:0] TargetD = 32'h0, RecoverPC_E = 32'h0;
    logic        StallD = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req, ValidD, branched_flag_F;
    logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
    logic        b_req, b_vd, b_br;
    logic [31:0] b_addr, b_ins, b_pcd, b_p4;
    int checks = 0, passed = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .TargetD(TargetD), .RecoverPC_E(RecoverPC_E),
        .StallD(StallD), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .branched_flag_F(branched_flag_F)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) wrap (
        .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .TargetD(TargetD), .RecoverPC_E(RecoverPC_E),
        .StallD(StallD), .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(b_ins), .PCD(b_pcd),
        .PCPlus4D(b_p4), .ValidD(b_vd), .branched_flag_F(b_br)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [1:0]  src;
        logic [31:0] tr;
        logic        g, rv;
        logic [31:0] ra;
        logic        req;
        logic [31:0] addr;
        logic        vd;
        logic [31:0] pcd;
        logic        br;
    } vec_t;

    function automatic logic [31:0] instr(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    function automatic vec_t v(input logic s, input logic [1:0] src, input logic [31:0] tr,
                               input logic g, input logic rv, input logic [31:0] ra,
                               input logic req, input logic [31:0] addr, input logic vd,
                               input logic [31:0] pcd, input logic br);
        vec_t r;
        r.s = s; r.src = src; r.tr = tr; r.g = g; r.rv = rv; r.ra = ra;
        r.req = req; r.addr = addr; r.vd = vd; r.pcd = pcd; r.br = br;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; StallD = 1'b0; PCSrcE = 2'b00; TargetD = 32'h0; RecoverPC_E = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1 chk("reset imem_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        chk("reset InstrD", InstrD, 32'h0000_0013);
        chk("reset PCD", PCD, 32'h0);
        chk("reset PCPlus4D", PCPlus4D, 32'h0);
        chk("reset ValidD", {31'b0, ValidD}, 32'd0);
        chk("reset branched", {31'b0, branched_flag_F}, 32'd0);
        reset = 1'b0;
    endtask

    vec_t tv[20];
    logic [31:0] exp_next, paddr, tgt_p, rec_p, ins_p, pcd_p, p4_p, addr_p;
    logic        exp_br, pend, s_p, redir_p, vd_p, req_p, gnt_p;
    logic [1:0]  src_p;
    int          cnt, loads;
    int unsigned r;

    initial begin
        // s src tr  g rv ra  | req addr vd pcd br
        tv[0]  = v(0, 2'd0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   0);
        tv[1]  = v(0, 2'd0, 32'h0,   1, 1, 32'h0,   1, 32'h4,   0, 32'h0,   0);
        tv[2]  = v(0, 2'd0, 32'h0,   1, 1, 32'h4,   1, 32'h8,   1, 32'h0,   0);
        tv[3]  = v(1, 2'd0, 32'h0,   0, 1, 32'h8,   0, 32'h0,   1, 32'h4,   0);
        tv[4]  = v(1, 2'd0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   0);
        tv[5]  = v(1, 2'd0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   0);
        tv[6]  = v(0, 2'd0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   0);
        tv[7]  = v(0, 2'd0, 32'h0,   1, 0, 32'h0,   1, 32'hC,   1, 32'h8,   0);
        tv[8]  = v(0, 2'd0, 32'h0,   1, 1, 32'hC,   1, 32'h10,  0, 32'h8,   0);
        tv[9]  = v(0, 2'd1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   1, 32'hC,   0);
        tv[10] = v(0, 2'd0, 32'h0,   0, 1, 32'h10,  0, 32'h0,   0, 32'hC,   1);
        tv[11] = v(0, 2'd0, 32'h0,   1, 0, 32'h0,   1, 32'h100, 0, 32'hC,   1);
        tv[12] = v(0, 2'd0, 32'h0,   0, 1, 32'h100, 1, 32'h104, 0, 32'hC,   1);
        tv[13] = v(1, 2'd0, 32'h0,   1, 0, 32'h0,   1, 32'h104, 1, 32'h100, 0);
        tv[14] = v(1, 2'd0, 32'h0,   0, 1, 32'h104, 0, 32'h0,   1, 32'h100, 0);
        tv[15] = v(1, 2'd2, 32'h14,  0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0);
        tv[16] = v(0, 2'd0, 32'h0,   0, 0, 32'h0,   1, 32'h14,  0, 32'h100, 0);
        tv[17] = v(0, 2'd0, 32'h0,   1, 0, 32'h0,   1, 32'h14,  0, 32'h100, 0);
        tv[18] = v(0, 2'd0, 32'h0,   0, 1, 32'h14,  1, 32'h18,  0, 32'h100, 0);
        tv[19] = v(0, 2'd0, 32'h0,   0, 0, 32'h0,   1, 32'h18,  1, 32'h14,  0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            StallD = tv[i].s; PCSrcE = tv[i].src; TargetD = tv[i].tr; RecoverPC_E = tv[i].tr;
            imem_gnt = tv[i].g; imem_rvalid = tv[i].rv;
            imem_rdata = tv[i].rv ? instr(tv[i].ra) : 32'hDEAD_BEEF;
            #1;
            chk($sformatf("vec%0d imem_req", i), {31'b0, imem_req}, {31'b0, tv[i].req});
            if (tv[i].req) chk($sformatf("vec%0d imem_addr", i), imem_addr, tv[i].addr);
            chk($sformatf("vec%0d ValidD", i), {31'b0, ValidD}, {31'b0, tv[i].vd});
            chk($sformatf("vec%0d PCD", i), PCD, tv[i].pcd);
            chk($sformatf("vec%0d branched", i), {31'b0, branched_flag_F}, {31'b0, tv[i].br});
            if (i >= 2) begin
                chk($sformatf("vec%0d InstrD", i), InstrD, instr(tv[i].pcd));
                chk($sformatf("vec%0d PCPlus4D", i), PCPlus4D, tv[i].pcd + 32'd4);
            end
            if (i == 0) chk("wrap first addr", b_addr, 32'hFFFF_FFFC);
            if (i == 1) chk("wrap second addr", b_addr, 32'h0);
            if (i == 2) begin
                chk("wrap first PCD", b_pcd, 32'hFFFF_FFFC);
                chk("wrap first PCPlus4D", b_p4, 32'h0);
            end
            @(negedge clk);
        end

        // Reset while a request is outstanding; the late response must be ignored.
        do_reset();
        imem_gnt = 1'b1;
        #1 chk("rst37 first req", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1; imem_gnt = 1'b0;
        #1 chk("rst37 req in reset", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
        #1 chk("rst37 req after release", {31'b0, imem_req}, 32'd1);
        chk("rst37 addr after release", imem_addr, 32'h0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1 chk("rst37 ValidD", {31'b0, ValidD}, 32'd0);
        chk("rst37 req held", {31'b0, imem_req}, 32'd1);
        chk("rst37 addr held", imem_addr, 32'h0);

        // Randomized run: the model tracks the expected program-order stream of delivered PCs.
        do_reset();
        exp_next = 32'h0; exp_br = 1'b0; pend = 1'b0; paddr = 32'h0; cnt = 0; loads = 0;
        s_p = 1'b0; redir_p = 1'b0; src_p = 2'b00; req_p = 1'b0; gnt_p = 1'b0;
        tgt_p = 32'h0; rec_p = 32'h0; addr_p = 32'h0; ins_p = 32'h0; pcd_p = 32'h0; p4_p = 32'h0; vd_p = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n > 0) begin
                if (redir_p) begin
                    chk("rnd redirect ValidD", {31'b0, ValidD}, 32'd0);
                    exp_next = src_p == 2'b10 ? rec_p : tgt_p;
                    exp_br = src_p == 2'b01;
                end else if (s_p) begin
                    chk("rnd stall InstrD", InstrD, ins_p);
                    chk("rnd stall PCD", PCD, pcd_p);
                    chk("rnd stall PCPlus4D", PCPlus4D, p4_p);
                    chk("rnd stall ValidD", {31'b0, ValidD}, {31'b0, vd_p});
                end else if (ValidD) begin
                    chk("rnd PCD order", PCD, exp_next);
                    chk("rnd InstrD", InstrD, instr(exp_next));
                    chk("rnd PCPlus4D", PCPlus4D, exp_next + 32'd4);
                    exp_next = exp_next + 32'd4;
                    exp_br = 1'b0;
                    loads++;
                end
                chk("rnd branched", {31'b0, branched_flag_F}, {31'b0, exp_br});
            end
            ins_p = InstrD; pcd_p = PCD; p4_p = PCPlus4D; vd_p = ValidD;
            StallD = ($urandom % 4) == 0;
            r = $urandom % 16;
            PCSrcE = r == 0 ? 2'b01 : r == 1 ? 2'b10 : r == 2 ? 2'b11 : 2'b00;
            TargetD = $urandom & ~32'h3;
            RecoverPC_E = $urandom & ~32'h3;
            imem_rvalid = pend && cnt == 0;
            imem_rdata = imem_rvalid ? instr(paddr) : $urandom;
            #1;
            if (req_p && !gnt_p && !redir_p) begin
                chk("rnd req held", {31'b0, imem_req}, 32'd1);
                chk("rnd addr held", imem_addr, addr_p);
            end
            if (pend && !imem_rvalid) chk("rnd no req while waiting", {31'b0, imem_req}, 32'd0);
            imem_gnt = imem_req && ($urandom % 3 != 0);
            redir_p = PCSrcE == 2'b10 || (PCSrcE == 2'b01 && !StallD);
            s_p = StallD; src_p = PCSrcE; tgt_p = TargetD; rec_p = RecoverPC_E;
            req_p = imem_req; gnt_p = imem_gnt; addr_p = imem_addr;
            if (imem_rvalid) pend = 1'b0;
            else if (pend) cnt--;
            if (imem_gnt) begin
                pend = 1'b1; paddr = imem_addr; cnt = $urandom % 3;
            end
            @(negedge clk);
        end
        chk("rnd progress", {31'b0, loads > 100}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be synchronous, active-high reset.
REQ-004 PCSrcE  in  2  SHALL select PC source: 00 sequential, 01 predicted-taken target from decode, 10 misprediction recovery, 11 treated as 00.
REQ-005 TargetD  in  32  SHALL be the branch/jump target computed in decode, used when PCSrcE=01.
REQ-006 RecoverPC_E  in  32  SHALL be the correct fall-through PC from execute, used when PCSrcE=10.
REQ-007 StallD  in  1  SHALL hold the IF/ID register when high.
REQ-008 imem_req  out  1, imem_addr  out  32  SHALL form the instruction-memory request.
REQ-009 imem_gnt  in  1  SHALL accept the request in the cycle it is high with imem_req.
REQ-010 imem_rvalid  in  1, imem_rdata  in  32  SHALL return one instruction per granted request, at least one cycle after grant.
REQ-011 InstrD, PCD, PCPlus4D  out  32 each, ValidD  out  1  SHALL be the registered IF/ID contents feeding decode.
REQ-012 branched_flag_F  out  1  SHALL flag that fetch is following a predicted-taken redirect.

Function
REQ-013 FSM states: REQ (request pending), WAIT (granted, awaiting rvalid), HOLD (instruction buffered during stall).
REQ-014 REQ: imem_req=1, imem_addr=PC held stable until imem_gnt; on gnt go to WAIT.
REQ-015 WAIT: on imem_rvalid with StallD=0 and no redirect, load IF/ID (InstrD=imem_rdata, PCD=PC of request, PCPlus4D=PCD+4, ValidD=1) and, in the same cycle, assert imem_req at PC+4 (back-to-back; stay WAIT on gnt, else REQ).
REQ-016 WAIT: on imem_rvalid with StallD=1, capture rdata into a one-entry buffer and go to HOLD; no new request while in HOLD.
REQ-017 HOLD: when StallD falls, load IF/ID from buffer, go to REQ at PC+4.
REQ-018 Adders SHALL be 32-bit modulo; PC 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 Only one request SHALL be outstanding; imem_req SHALL never rise in WAIT without same-cycle rvalid.
REQ-020 Redirect priority: PCSrcE=10 over StallD over PCSrcE=01 over sequential.
REQ-021 PCSrcE=10: PC<=RecoverPC_E, ValidD<=0, buffer discarded, branched_flag_F<=0, regardless of StallD.
REQ-022 PCSrcE=01 with StallD=0: PC<=TargetD, ValidD<=0 (squash fall-through), branched_flag_F<=1; PCSrcE=01 with StallD=1 SHALL be ignored.
REQ-023 branched_flag_F SHALL clear on the edge the first target-path instruction loads into IF/ID, or on recovery.
REQ-024 Redirect while in REQ-after-grant or WAIT SHALL set a drop flag; the matching rvalid is consumed without loading IF/ID, then go to REQ at the new PC.
REQ-025 Redirect in REQ before gnt SHALL update imem_addr on the next cycle (ungranted request may change).
REQ-026 Redirect coinciding with rvalid SHALL drop that response.
REQ-027 StallD=1 with no redirect SHALL keep all IF/ID outputs unchanged.

Reset
REQ-028 On reset: PC=RESET_PC, state=REQ, drop flag=0, buffer empty, imem_req=0 in reset cycle.
REQ-029 Reset values: InstrD=32'h0000_0013, PCD=0, PCPlus4D=0, ValidD=0, branched_flag_F=0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a later stray rvalid in REQ SHALL be ignored.
REQ-031 First cycle after reset release SHALL assert imem_req with imem_addr=RESET_PC.

Verification
REQ-032 Zero-wait memory (gnt same cycle, rvalid next), no stalls -> addresses 0,4,8,... one per cycle; ValidD=1 from 2nd cycle after reset release.
REQ-033 StallD high 3 cycles while rvalid arrives for addr 0x8 -> InstrD unchanged during stall, buffered instr at PCD=0x8 appears cycle after StallD falls, next request 0xC.
REQ-034 PCSrcE=01, TargetD=0x100 while request 0x10 in WAIT -> 0x10 response dropped, ValidD=0, next imem_addr=0x100, branched_flag_F=1 until instr 0x100 loads.
REQ-035 PCSrcE=10, RecoverPC_E=0x14 with StallD=1 and HOLD active -> buffer discarded, ValidD=0, next imem_addr=0x14, branched_flag_F=0.
REQ-036 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000, PCPlus4D=0 for first instruction.
REQ-037 Reset asserted in WAIT, rvalid arrives cycle after release -> ignored, imem_addr=RESET_PC, ValidD stays 0.
